// File: rtl/onehot_strobe_decoder.sv
// Binary-to-one-hot strobe decoder. Codes are buffered in a small FIFO, and each one
// is replayed as a registered one-hot strobe held for HOLD cycles.
module onehot_strobe_decoder #(
  parameter int WIDTH = 3,
  parameter int HOLD  = 4,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_code,
  output logic [2**WIDTH-1:0]          out,
  output logic                         out_valid,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int OW = 2**WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [7:0] CNT_INIT = 8'(HOLD - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t           state, state_d;
  logic [7:0]       cnt, cnt_d;
  logic [OW-1:0]    out_d;
  logic             out_valid_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop, fifo_nonempty;

  // in_ready ignores a same-cycle pop, so a write never lands on a full FIFO.
  assign in_ready      = (level != LW'(DEPTH));
  assign push          = in_valid && in_ready && !clr;
  assign fifo_nonempty = (level != '0);
  assign busy          = (state == S_HOLD) || fifo_nonempty;

  // NOTE: the storage array has no reset; level and the pointers decide what is valid,
  // so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    out_d       = out;
    out_valid_d = out_valid;
    pop         = 1'b0;
    if (clr) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      out_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (fifo_nonempty) begin
            pop         = 1'b1;
            state_d     = S_HOLD;
            out_d       = OW'(1) << mem[rd_ptr];
            out_valid_d = 1'b1;
            cnt_d       = CNT_INIT;
          end
        end
        S_HOLD: begin
          if (cnt != '0) begin
            cnt_d = cnt - 8'd1;
          end else if (fifo_nonempty) begin
            // Last strobe cycle with more work queued: reload with no gap.
            pop         = 1'b1;
            out_d       = OW'(1) << mem[rd_ptr];
            out_valid_d = 1'b1;
            cnt_d       = CNT_INIT;
          end else begin
            state_d     = S_IDLE;
            out_d       = '0;
            out_valid_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      out       <= out_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Scoreboard bench for onehot_strobe_decoder: stimulus queues accepted codes, and a
// monitor checks each strobe's code, one-hotness and length.
module tb_onehot_strobe_decoder;

  localparam int WIDTH = 3;
  localparam int HOLD  = 4;
  localparam int DEPTH = 2;
  localparam int OW    = 2**WIDTH;
  localparam int LW    = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_n, clr, in_valid, in_ready, out_valid, busy;
  logic [WIDTH-1:0]  in_code;
  logic [OW-1:0]     out;
  logic [LW-1:0]     level;

  onehot_strobe_decoder #(.WIDTH(WIDTH), .HOLD(HOLD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out(out), .out_valid(out_valid), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  bit abort_ok = 1'b0;

  // Monitor-owned bookkeeping.
  int          run_cnt = 0;
  logic [OW-1:0] cur_exp = '0;
  int          strobes_seen = 0;
  int          valid_cycles = 0;
  int          valid_falls = 0;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [OW-1:0] one;
    one = OW'(1);
    if (out_valid === 1'b1) begin
      valid_cycles++;
      if (run_cnt == 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(out), 32'd0);
        end else begin
          cur_exp = one << exp_q.pop_front();
          strobes_seen++;
          check("strobe_code", 32'(out), 32'(cur_exp));
        end
      end else begin
        check("strobe_held", 32'(out), 32'(cur_exp));
      end
      check("onehot", 32'($countones(out)), 32'd1);
      run_cnt = (run_cnt == HOLD-1) ? 0 : run_cnt + 1;
    end else begin
      if (prev_valid === 1'b1) valid_falls++;
      if (run_cnt != 0 && !abort_ok) check("strobe_length", 32'(run_cnt), 32'(HOLD));
      run_cnt = 0;
      if (rst_n === 1'b1) check("idle_out_zero", 32'(out), 32'd0);
    end
    prev_valid = out_valid;
  end

  // Called at a negedge; applies inputs for the next rising edge, returns at the next negedge.
  task automatic drive(input bit v, input logic [WIDTH-1:0] c, input bit cl, output bit acc);
    in_valid = v;
    in_code  = c;
    clr      = cl;
    #1;
    acc = 1'b0;
    if (cl) begin
      exp_q.delete();
      abort_ok = 1'b1;
    end else begin
      abort_ok = 1'b0;
      if (v && in_ready) begin
        exp_q.push_back(int'(c));
        acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) drive(1'b0, '0, 1'b0, a);
  endtask

  task automatic push_code(input logic [WIDTH-1:0] c);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 50 && !a; i++) drive(1'b1, c, 1'b0, a);
    if (!a) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      if (busy === 1'b0 && out_valid === 1'b0) break;
      idle(1);
    end
    if (i == 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bit a;
    int vc0, vf0, ss0, acc_cnt;

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_code = '0;
    #3;
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single push of code 5: strobe 8'h20 for four cycles, then idle.
    drive(1'b1, 3'd5, 1'b0, a);
    check("single_level", 32'(level), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    check("single_prestrobe", 32'(out_valid), 32'd0);
    for (int i = 1; i <= HOLD; i++) begin
      idle(1);
      check("single_out", 32'(out), 32'h20);
      check("single_valid", 32'(out_valid), 32'd1);
    end
    idle(1);
    check("single_end_out", 32'(out), 32'd0);
    check("single_end_valid", 32'(out_valid), 32'd0);
    check("single_end_busy", 32'(busy), 32'd0);

    // Back-to-back 0,7,3: twelve contiguous strobe cycles and FIFO-full backpressure.
    vc0 = valid_cycles; vf0 = valid_falls;
    drive(1'b1, 3'd0, 1'b0, a);
    check("b2b_level1", 32'(level), 32'd1);
    drive(1'b1, 3'd7, 1'b0, a);
    check("b2b_level_pushpop", 32'(level), 32'd1);
    drive(1'b1, 3'd3, 1'b0, a);
    check("b2b_level_full", 32'(level), 32'd2);
    check("b2b_ready_low", 32'(in_ready), 32'd0);
    idle(1);
    check("b2b_still_full", 32'(in_ready), 32'd0);
    idle(2);
    check("b2b_level_after_pop", 32'(level), 32'd1);
    check("b2b_ready_back", 32'(in_ready), 32'd1);
    wait_idle();
    check("b2b_valid_cycles", 32'(valid_cycles - vc0), 32'(3*HOLD));
    check("b2b_no_gap", 32'(valid_falls - vf0), 32'd1);

    // Every code once.
    ss0 = strobes_seen;
    for (int n = 0; n < OW; n++) push_code(WIDTH'(n));
    wait_idle();
    check("exhaustive_count", 32'(strobes_seen - ss0), 32'(OW));

    // in_valid held high for 12 cycles: accepts at edges 0,1,2,6,10.
    acc_cnt = 0;
    ss0 = strobes_seen;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0, a);
      if (a) acc_cnt++;
      if (i == 2) begin
        check("full_level", 32'(level), 32'd2);
        check("full_ready", 32'(in_ready), 32'd0);
      end
      if (level > LW'(DEPTH)) check("full_overflow", 32'(level), 32'(DEPTH));
    end
    check("full_accepts", 32'(acc_cnt), 32'd5);
    wait_idle();
    check("full_strobes", 32'(strobes_seen - ss0), 32'd5);

    // clr mid-strobe with two codes queued and a push presented.
    ss0 = strobes_seen;
    drive(1'b1, 3'd1, 1'b0, a);
    drive(1'b1, 3'd2, 1'b0, a);
    drive(1'b1, 3'd4, 1'b0, a);
    check("clr_pre_level", 32'(level), 32'd2);
    drive(1'b1, 3'd6, 1'b1, a);
    check("clr_out", 32'(out), 32'd0);
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_level", 32'(level), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    // clr while a push would otherwise be accepted.
    drive(1'b1, 3'd5, 1'b0, a);
    drive(1'b1, 3'd6, 1'b1, a);
    check("clr_drop_level", 32'(level), 32'd0);
    idle(HOLD + 2);
    check("clr_no_strobe", 32'(strobes_seen - ss0), 32'd1);
    check("clr_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-HOLD, then a fresh push of code 2.
    push_code(3'd3);
    idle(2);
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    abort_ok = 1'b1;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("arst_out", 32'(out), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vc0 = valid_cycles;
    drive(1'b1, 3'd2, 1'b0, a);
    idle(1);
    check("arst_push_out", 32'(out), 32'h04);
    wait_idle();
    check("arst_push_len", 32'(valid_cycles - vc0), 32'(HOLD));

    idle(2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
